// File: rtl/fp_adder_if.sv
// Operand/result bundle for the binary32 adder: operand pair in, registered sum out.
interface fp_adder_if;
    logic        in_valid;
    logic [31:0] number_1;
    logic [31:0] number_2;
    logic [31:0] out;
    logic        out_valid;

    modport master (
        output in_valid, number_1, number_2,
        input  out, out_valid
    );

    modport slave (
        input  in_valid, number_1, number_2,
        output out, out_valid
    );
endinterface

// File: rtl/fp_adder.sv
// Binary32 adder, round-to-nearest-even, one registered output stage.
// Define FP_ADDER_SUBNORMAL_EN for gradual underflow; default flushes subnormals to zero.
module fp_adder (
    input  logic     clk,
    input  logic     rst,
    fp_adder_if.slave bus
);

`ifdef FP_ADDER_SUBNORMAL_EN
    localparam bit SUB_EN = 1'b1;
`else
    localparam bit SUB_EN = 1'b0;
`endif

    logic [31:0] op      [0:1];
    logic        sign    [0:1];
    logic [7:0]  exp_raw [0:1];
    logic [22:0] frac    [0:1];
    logic [7:0]  exp     [0:1];
    logic [23:0] mantis  [0:2];
    logic        is_nan  [0:1];
    logic        is_inf  [0:1];
    logic        is_zero [0:1];
    logic        carry;

    assign op[0] = bus.number_1;
    assign op[1] = bus.number_2;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_unpack
            assign sign[gi]    = op[gi][31];
            assign exp_raw[gi] = op[gi][30:23];
            assign frac[gi]    = op[gi][22:0];
            // Subnormals run at effective exponent 1 with no hidden bit.
            assign exp[gi]     = (exp_raw[gi] == 8'd0) ? 8'd1 : exp_raw[gi];
            assign mantis[gi]  = {exp_raw[gi] != 8'd0, frac[gi]};
            assign is_nan[gi]  = (exp_raw[gi] == 8'hFF) && (frac[gi] != 23'd0);
            assign is_inf[gi]  = (exp_raw[gi] == 8'hFF) && (frac[gi] == 23'd0);
            assign is_zero[gi] = (exp_raw[gi] == 8'd0) && ((frac[gi] == 23'd0) || !SUB_EN);
        end
    endgenerate

    logic               swap;
    logic [7:0]         exp_big, exp_small, exp_diff;
    logic [23:0]        sig_big, sig_small;
    logic               sign_big;
    logic [4:0]         shift_amt;
    logic [49:0]        shifted;
    logic [26:0]        aligned;
    logic [27:0]        raw_sum;
    logic [4:0]         lz, lz_eff;
    logic signed [9:0]  exp_pre, exp_norm, exp_fin;
    logic [26:0]        norm;
    logic               round_up;
    logic [24:0]        rounded;
    logic [23:0]        mantis_res;
    logic [31:0]        arith_res, sum_res;

    always_comb begin
        swap      = {exp[1], mantis[1]} > {exp[0], mantis[0]};
        exp_big   = swap ? exp[1]    : exp[0];
        exp_small = swap ? exp[0]    : exp[1];
        sig_big   = swap ? mantis[1] : mantis[0];
        sig_small = swap ? mantis[0] : mantis[1];
        sign_big  = swap ? sign[1]   : sign[0];

        exp_diff  = exp_big - exp_small;
        shift_amt = (exp_diff > 8'd26) ? 5'd26 : exp_diff[4:0];
        shifted   = {sig_small, 26'd0} >> shift_amt;
        // Keep 24 significand bits plus guard and round; everything below folds into sticky.
        aligned   = {shifted[49:24], |shifted[23:0]};

        if (sign[0] ^ sign[1])
            raw_sum = {1'b0, sig_big, 3'b000} - {1'b0, aligned};
        else
            raw_sum = {1'b0, sig_big, 3'b000} + {1'b0, aligned};
        carry = raw_sum[27];

        lz = 5'd27;
        for (int i = 0; i < 27; i++) begin
            if (raw_sum[i]) lz = 5'(26 - i);
        end
        exp_pre = $signed({2'b00, exp_big}) - $signed({5'd0, lz});
        // With gradual underflow, stop normalizing once the exponent reaches 1.
        if (SUB_EN && (exp_pre < 10'sd1))
            lz_eff = 5'(exp_big - 8'd1);
        else
            lz_eff = lz;

        if (carry) begin
            norm     = {raw_sum[27:2], raw_sum[1] | raw_sum[0]};
            exp_norm = $signed({2'b00, exp_big}) + 10'sd1;
        end else begin
            norm     = raw_sum[26:0] << lz_eff;
            exp_norm = $signed({2'b00, exp_big}) - $signed({5'd0, lz_eff});
        end

        round_up   = norm[2] & (norm[1] | norm[0] | norm[3]);
        rounded    = {1'b0, norm[26:3]} + {24'd0, round_up};
        mantis_res = rounded[24] ? rounded[24:1] : rounded[23:0];
        if (rounded[24])
            exp_fin = exp_norm + 10'sd1;
        else if (mantis_res[23])
            exp_fin = exp_norm;
        else
            exp_fin = 10'sd0;

        if (raw_sum == 28'd0)
            arith_res = 32'h0000_0000;
        else if (!SUB_EN && (exp_norm <= 10'sd0))
            arith_res = {sign_big, 31'd0};
        else if (exp_fin >= 10'sd255)
            arith_res = {sign_big, 8'hFF, 23'd0};
        else
            arith_res = {sign_big, exp_fin[7:0], mantis_res[22:0]};

        if (is_nan[0] || is_nan[1] || (is_inf[0] && is_inf[1] && (sign[0] != sign[1])))
            sum_res = 32'h7FC0_0000;
        else if (is_inf[0])
            sum_res = op[0];
        else if (is_inf[1])
            sum_res = op[1];
        else if (is_zero[0] && is_zero[1])
            sum_res = {sign[0] & sign[1], 31'd0};
        else if (is_zero[0])
            sum_res = op[1];
        else if (is_zero[1])
            sum_res = op[0];
        else
            sum_res = arith_res;
    end

    assign mantis[2] = mantis_res;

    logic [31:0] out_q, out_d;
    logic        out_valid_q, out_valid_d;

    always_comb begin
        out_d       = bus.in_valid ? sum_res : out_q;
        out_valid_d = bus.in_valid;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q       <= 32'h0000_0000;
            out_valid_q <= 1'b0;
        end else begin
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.out       = out_q;
    assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_fp_adder.sv
// Bench for fp_adder: directed cases, reset priority, then random pairs checked
// against a real-arithmetic binary32 model.
module tb_fp_adder;

`ifdef FP_ADDER_SUBNORMAL_EN
    localparam bit SUB = 1'b1;
`else
    localparam bit SUB = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fp_adder_if bus ();
    fp_adder dut (.clk(clk), .rst(rst), .bus(bus));

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, want);
        end
    endtask

    function automatic bit is_zero_op(input logic [31:0] x);
        return (x[30:23] == 8'd0) && ((x[22:0] == 23'd0) || !SUB);
    endfunction

    function automatic real to_real(input logic [31:0] x);
        logic [10:0] de;
        real         v;
        if (x[30:23] == 8'd0) begin
            if (!SUB) return 0.0;
            v = real'(x[22:0]) * (2.0 ** -149.0);
            return x[31] ? -v : v;
        end
        de = {3'b000, x[30:23]} + 11'd896;
        return $bitstoreal({x[31], de, x[22:0], 29'd0});
    endfunction

    // Rounds a double to binary32 with ties-to-even; a double sum of two
    // binary32 values rounded this way equals the correctly rounded sum.
    function automatic logic [31:0] from_real(input real d);
        logic [63:0]     bits;
        logic            s;
        longint unsigned mant, q, rem, half;
        int              e32, sh;
        if (d == 0.0) return 32'h0000_0000;
        bits = $realtobits(d);
        s    = bits[63];
        mant = {11'd0, 1'b1, bits[51:0]};
        e32  = int'(bits[62:52]) - 1023 + 127;
        if (!SUB && e32 <= 0) return {s, 31'd0};
        sh = (e32 >= 1) ? 29 : 30 - e32;
        if (sh > 60) return {s, 31'd0};
        q    = mant >> sh;
        rem  = mant & ((64'd1 << sh) - 64'd1);
        half = 64'd1 << (sh - 1);
        if (rem > half || (rem == half && (q & 64'd1) != 0)) q = q + 1;
        if (e32 >= 1) begin
            if (q == (64'd1 << 24)) begin
                q   = q >> 1;
                e32 = e32 + 1;
            end
            if (e32 >= 255) return {s, 8'hFF, 23'd0};
            return {s, 8'(e32), q[22:0]};
        end
        if (q >= (64'd1 << 23)) return {s, 8'd1, q[22:0]};
        return {s, 8'd0, q[22:0]};
    endfunction

    function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b);
        bit nan_a, nan_b, inf_a, inf_b;
        nan_a = (a[30:23] == 8'hFF) && (a[22:0] != 0);
        nan_b = (b[30:23] == 8'hFF) && (b[22:0] != 0);
        inf_a = (a[30:23] == 8'hFF) && (a[22:0] == 0);
        inf_b = (b[30:23] == 8'hFF) && (b[22:0] == 0);
        if (nan_a || nan_b) return 32'h7FC0_0000;
        if (inf_a && inf_b) return (a[31] == b[31]) ? a : 32'h7FC0_0000;
        if (inf_a) return a;
        if (inf_b) return b;
        if (is_zero_op(a) && is_zero_op(b)) return {a[31] & b[31], 31'd0};
        return from_real(to_real(a) + to_real(b));
    endfunction

    function automatic logic [31:0] rand_op(input int base);
        int sel, e;
        sel = int'($urandom_range(0, 19));
        case (sel)
            0: return {$urandom_range(0, 1) == 1, 31'd0};
            1: return {$urandom_range(0, 1) == 1, 8'hFF, 23'd0};
            2: return {1'b0, 8'hFF, 23'($urandom_range(1, 32'h7FFFFF))};
            3: return {$urandom_range(0, 1) == 1, 8'd0, 23'($urandom_range(1, 32'h7FFFFF))};
            default: begin
                e = base + int'($urandom_range(0, 30)) - 15;
                if (e < 1) e = 1;
                if (e > 254) e = 254;
                return {$urandom_range(0, 1) == 1, 8'(e), 23'($urandom)};
            end
        endcase
    endfunction

    task automatic apply(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] want);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.number_1 = a;
        bus.number_2 = b;
        @(posedge clk);
        #1;
        $display("txn %s: %08h + %08h -> %08h (want %08h)", tag, a, b, bus.out, want);
        check(tag, bus.out, want);
        check({tag, "_valid"}, {31'd0, bus.out_valid}, 32'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.number_1 = $urandom;
        bus.number_2 = $urandom;
        @(posedge clk);
        #1;
        check({tag, "_hold"}, bus.out, want);
        check({tag, "_idle"}, {31'd0, bus.out_valid}, 32'd0);
    endtask

    logic [31:0] dir_a [0:10];
    logic [31:0] dir_b [0:10];
    logic [31:0] dir_r [0:10];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        logic [31:0] a, b;
        int          base;

        dir_a = '{32'h40200000, 32'h40A00000, 32'h40600000, 32'h3F800000, 32'h3F800000,
                  32'h3F800001, 32'h7F7FFFFF, 32'h7F800000, 32'h7FC00001, 32'h00400000,
                  32'h80000000};
        dir_b = '{32'h40600000, 32'h40200000, 32'hC0000000, 32'hBF800000, 32'h33800000,
                  32'h33800000, 32'h7F7FFFFF, 32'hFF800000, 32'h3F800000, 32'h00400000,
                  32'h80000000};
        dir_r = '{32'h40C00000, 32'h40F00000, 32'h3FC00000, 32'h00000000, 32'h3F800000,
                  32'h3F800002, 32'h7F800000, 32'h7FC00000, 32'h7FC00000,
                  SUB ? 32'h00800000 : 32'h00000000, 32'h80000000};

        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.number_1 = 32'd0;
        bus.number_2 = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_out", bus.out, 32'd0);
        check("reset_valid", {31'd0, bus.out_valid}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 11; i++) begin
            apply($sformatf("dir%0d", i), dir_a[i], dir_b[i], dir_r[i]);
        end

        // Reset at the same edge as a valid pair must discard that pair.
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.number_1 = 32'h3F800000;
        bus.number_2 = 32'h3F800000;
        rst          = 1'b1;
        @(posedge clk);
        #1;
        $display("txn rst_edge: out %08h valid %0d", bus.out, bus.out_valid);
        check("rst_edge_out", bus.out, 32'd0);
        check("rst_edge_valid", {31'd0, bus.out_valid}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        $display("txn rst_release: out %08h valid %0d", bus.out, bus.out_valid);
        check("rst_release_out", bus.out, 32'h40000000);
        check("rst_release_valid", {31'd0, bus.out_valid}, 32'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;

        for (int n = 0; n < 100; n++) begin
            case ($urandom_range(0, 3))
                0:       base = int'($urandom_range(1, 12));
                1:       base = int'($urandom_range(244, 254));
                default: base = int'($urandom_range(1, 254));
            endcase
            a = rand_op(base);
            case ($urandom_range(0, 7))
                0:       b = a ^ 32'h8000_0000;
                1:       b = {~a[31], a[30:0] ^ 32'($urandom_range(1, 7))};
                default: b = rand_op(base);
            endcase
            apply($sformatf("rnd%0d", n), a, b, model(a, b));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
